// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose
//   Instruction fetch front end. It owns the program counter, issues one
//   outstanding request at a time to instruction memory, and registers the
//   returned word together with the address it came from. It also handles
//   three other cases:
//     - Redirects (Branch_Taken / Branch_Target). A redirect that arrives
//       while a request is still outstanding is parked in a pending register.
//       It is applied when the memory answers, and the stale word is dropped.
//     - Downstream back-pressure (Stall). Once a word has been captured, Stall
//       parks the unit in HOLD with the word presented.
//     - Faults. A misaligned redirect target, or a memory that does not answer
//       within TIMEOUT_CYCLES, drives the unit into FAULT. FAULT is sticky
//       until rst_n is asserted.
//
// Parameters
//   RESET_PC        PC value loaded while rst_n is low.
//   TIMEOUT_CYCLES  Number of consecutive unacknowledged REQ cycles that
//                   raise the fault (1..255).
//
// Ports
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   Next_PC        in  32   PC + 4 from the external incrementer stage
//   Branch_Target  in  32   redirect address
//   Branch_Taken   in   1   redirect request
//   Stall          in   1   downstream cannot take Instr
//   imem_ack       in   1   instruction memory answered the current request
//   imem_rdata     in  32   instruction word returned with imem_ack
//   PC             out 32   current fetch address
//   imem_req       out  1   fetch request (high only in REQ)
//   imem_addr      out 32   fetch address (equals PC)
//   Instr          out 32   last accepted instruction word
//   Instr_PC       out 32   address Instr was fetched from
//   Instr_Valid    out  1   Instr / Instr_PC valid
//   Fetch_Fault    out  1   sticky fault flag
// -----------------------------------------------------------------------------

// Invariant checker: watches the fetch unit's outputs.
module pc_fetch_unit_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic imem_req,
    input  logic instr_valid,
    input  logic fetch_fault
);
    logic fault_seen_q;

    // Remember whether the fault flag was already raised at the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_seen_q <= 1'b0;
        end else begin
            fault_seen_q <= fetch_fault;
        end
    end

    // Output invariants: no request or valid data while faulted; fault is sticky.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_req && fetch_fault));
            assert (!(instr_valid && fetch_fault));
            assert (!fault_seen_q || fetch_fault);
        end
    end
endmodule

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Next_PC,
    input  logic [31:0] Branch_Target,
    input  logic        Branch_Taken,
    input  logic        Stall,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] Instr,
    output logic [31:0] Instr_PC,
    output logic        Instr_Valid,
    output logic        Fetch_Fault
);

    // Canonical NOP (addi x0, x0, 0) presented while nothing has been fetched.
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        HOLD  = 2'b10,
        FAULT = 2'b11
    } state_e;

    // Instruction addresses must be word aligned.
    function automatic logic misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    state_e      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q,    valid_d;
    logic        fault_q,    fault_d;
    logic        req_q,      req_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        pend_q,     pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        redirect_s;
    logic [31:0] redirect_tgt_s;
    logic [7:0]  wait_cnt_inc_s;

    // A redirect presented in this cycle wins over an older parked one.
    always_comb begin
        redirect_s     = Branch_Taken | pend_q;
        redirect_tgt_s = Branch_Taken ? Branch_Target : pend_tgt_q;
        wait_cnt_inc_s = wait_cnt_q + 8'd1;
    end

    // Next-state and next-output logic for the fetch state machine.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        wait_cnt_d = wait_cnt_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;

        case (state_q)
            IDLE: begin
                // Any stray ack arriving here belongs to an abandoned request.
                state_d    = REQ;
                wait_cnt_d = 8'd0;
            end

            REQ: begin
                if (Branch_Taken && misaligned(Branch_Target)) begin
                    // The target is checked when the redirect is sampled, so
                    // the pending register only ever holds aligned targets.
                    state_d = FAULT;
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                    pend_d  = 1'b0;
                end else if (imem_ack) begin
                    wait_cnt_d = 8'd0;
                    if (redirect_s) begin
                        // The returned word belongs to the abandoned path.
                        pc_d    = redirect_tgt_s;
                        valid_d = 1'b0;
                        pend_d  = 1'b0;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        if (Stall) begin
                            state_d = HOLD;
                        end else begin
                            pc_d = Next_PC;
                        end
                    end
                end else begin
                    // The request stays outstanding; only the wait count moves.
                    valid_d    = 1'b0;
                    wait_cnt_d = wait_cnt_inc_s;
                    if (wait_cnt_inc_s >= TIMEOUT_LIMIT) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        pend_d  = 1'b0;
                    end else if (Branch_Taken) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = Branch_Target;
                    end else begin
                        pend_d = pend_q;
                    end
                end
            end

            HOLD: begin
                if (Branch_Taken) begin
                    if (misaligned(Branch_Target)) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        pc_d       = Branch_Target;
                        valid_d    = 1'b0;
                        wait_cnt_d = 8'd0;
                        state_d    = REQ;
                    end
                end else if (!Stall) begin
                    pc_d       = Next_PC;
                    valid_d    = 1'b0;
                    wait_cnt_d = 8'd0;
                    state_d    = REQ;
                end else begin
                    state_d = HOLD;
                end
            end

            FAULT: begin
                valid_d = 1'b0;
                fault_d = 1'b1;
            end

            default: begin
                state_d = FAULT;
                fault_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase

        // The request strobe is registered so it does not depend on inputs.
        req_d = (state_d == REQ);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            req_q      <= 1'b0;
            wait_cnt_q <= 8'd0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            req_q      <= req_d;
            wait_cnt_q <= wait_cnt_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign PC          = pc_q;
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign Instr_PC    = instr_pc_q;
    assign Instr_Valid = valid_q;
    assign Fetch_Fault = fault_q;

    pc_fetch_unit_chk u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (req_q),
        .instr_valid (valid_q),
        .fetch_fault (fault_q)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit. Directed scenarios are run first, then
// randomized traffic. All traffic is checked against a behavioural model of
// the fetch rules.
module tb_pc_fetch_unit;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic [31:0] Next_PC;
    logic [31:0] Branch_Target;
    logic        Branch_Taken;
    logic        Stall;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_Valid;
    logic        Fetch_Fault;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    logic [31:0] m_pc, m_instr, m_ipc, m_ptgt;
    bit          m_valid, m_fault, m_booted, m_holding, m_pend;
    int          m_wait;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Next_PC       (Next_PC),
        .Branch_Target (Branch_Target),
        .Branch_Taken  (Branch_Taken),
        .Stall         (Stall),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .PC            (PC),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .Instr         (Instr),
        .Instr_PC      (Instr_PC),
        .Instr_Valid   (Instr_Valid),
        .Fetch_Fault   (Fetch_Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0000_0013; m_ipc = 32'h0; m_ptgt = 32'h0;
        m_valid = 1'b0; m_fault = 1'b0; m_booted = 1'b0; m_holding = 1'b0;
        m_pend = 1'b0; m_wait = 0;
    endtask

    task automatic enter_fault();
        m_fault = 1'b1; m_valid = 1'b0; m_pend = 1'b0;
    endtask

    // Apply one rising edge worth of fetch rules to the model.
    task automatic model_edge(input bit bt, input logic [31:0] tgt, input bit stall,
                              input bit ack, input logic [31:0] rdata, input logic [31:0] npc);
        logic [1:0] low;
        low = tgt[1:0];
        if (m_fault) begin
            m_valid = 1'b0;
        end else if (!m_booted) begin
            m_booted = 1'b1;
            m_wait   = 0;
        end else if (m_holding) begin
            if (bt) begin
                if (low != 2'b00) enter_fault();
                else begin m_pc = tgt; m_valid = 1'b0; m_holding = 1'b0; m_wait = 0; end
            end else if (!stall) begin
                m_pc = npc; m_valid = 1'b0; m_holding = 1'b0; m_wait = 0;
            end
        end else begin
            if (bt && low != 2'b00) begin
                enter_fault();
            end else if (ack) begin
                m_wait = 0;
                if (bt || m_pend) begin
                    m_pc = bt ? tgt : m_ptgt; m_valid = 1'b0; m_pend = 1'b0;
                end else begin
                    m_instr = rdata; m_ipc = m_pc; m_valid = 1'b1;
                    if (stall) m_holding = 1'b1;
                    else m_pc = npc;
                end
            end else begin
                m_valid = 1'b0;
                m_wait  = m_wait + 1;
                if (m_wait >= TIMEOUT) enter_fault();
                else if (bt) begin m_pend = 1'b1; m_ptgt = tgt; end
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_req;
        exp_req = m_booted && !m_holding && !m_fault;
        chk({tag, "_pc"},    PC,                   m_pc);
        chk({tag, "_req"},   {31'd0, imem_req},    {31'd0, exp_req});
        if (exp_req) chk({tag, "_addr"}, imem_addr, m_pc);
        chk({tag, "_instr"}, Instr,                m_instr);
        chk({tag, "_ipc"},   Instr_PC,             m_ipc);
        chk({tag, "_valid"}, {31'd0, Instr_Valid}, {31'd0, m_valid});
        chk({tag, "_fault"}, {31'd0, Fetch_Fault}, {31'd0, m_fault});
    endtask

    // Called just after a falling edge; returns after the next falling edge.
    task automatic step(input bit bt, input logic [31:0] tgt, input bit stall,
                        input bit ack, input logic [31:0] rdata, input string tag);
        Branch_Taken  = bt;
        Branch_Target = tgt;
        Stall         = stall;
        imem_ack      = ack;
        imem_rdata    = rdata;
        Next_PC       = m_pc + 32'd4;
        model_edge(bt, tgt, stall, ack, rdata, m_pc + 32'd4);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // Pulse reset between edges and check the asynchronous effect before the next edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        Branch_Taken = 1'b0; Stall = 1'b0; imem_ack = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        chk({tag, "_nop"}, Instr, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
        check_all({tag, "_rel"});
        // A late ack during the first cycle after release must be ignored.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, {tag, "_boot"});
    endtask

    initial begin
        logic [31:0] fault_pc;
        rst_n = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'h0; Stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; Next_PC = 32'h4;
        model_reset();
        @(negedge clk);
        do_reset("por");
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        chk("boot_instr", Instr, 32'h0000_0013);

        // Back-to-back fetch with ack every cycle.
        for (int i = 0; i < 4; i++) begin
            chk("t033_addr", imem_addr, 32'(i * 4));
            step(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), "t033");
            chk("t033_ipc", Instr_PC, 32'(i * 4));
            chk("t033_valid", {31'd0, Instr_Valid}, 32'd1);
        end

        // Redirect during an unacknowledged fetch of 0x10.
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, "t035_park");
        chk("t035_addr_hold", imem_addr, 32'h10);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, "t035_drop");
        chk("t035_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("t035_instr", Instr, 32'hC);
        chk("t035_addr", imem_addr, 32'h100);

        // Current redirect beats a parked one.
        step(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, "prio_park");
        step(1'b1, 32'h300, 1'b0, 1'b1, 32'h1, "prio_ack");
        chk("prio_addr", imem_addr, 32'h300);

        // Wrap of the address space.
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0, "wrap_rd");
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1, "wrap_a");
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h2, "wrap_b");
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_ipc", Instr_PC, 32'hFFFF_FFFC);

        // Branch beats Stall in HOLD.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h3, "hb_hold");
        step(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, "hb_br");
        chk("hb_addr", imem_addr, 32'h40);

        // Timeout boundary: 14 idle cycles then ack is fine; 15 faults.
        repeat (14) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "t037_w14");
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h5, "t037_ack");
        chk("t037_nofault", {31'd0, Fetch_Fault}, 32'd0);
        repeat (14) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "t037_w");
        chk("t037_pre", {31'd0, Fetch_Fault}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "t037_15");
        chk("t037_fault", {31'd0, Fetch_Fault}, 32'd1);
        fault_pc = m_pc;
        repeat (3) step(1'b1, 32'h80, 1'b0, 1'b1, 32'h7, "t037_abs");
        chk("t037_pc_held", PC, fault_pc);

        // Stall at PC=8.
        do_reset("t034_rst");
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, "t034_a0");
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4, "t034_a4");
        chk("t034_addr8", imem_addr, 32'h8);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hA5A5_0008, "t034_ack");
        repeat (3) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "t034_hold");
            chk("t034_instr", Instr, 32'hA5A5_0008);
            chk("t034_req", {31'd0, imem_req}, 32'd0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "t034_go");
        chk("t034_addrC", imem_addr, 32'hC);

        // Reset mid-request; the late ack is ignored inside do_reset.
        do_reset("t032");

        // Misaligned redirect.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h11, "t036_a");
        step(1'b1, 32'h102, 1'b0, 1'b0, 32'h0, "t036_br");
        chk("t036_fault", {31'd0, Fetch_Fault}, 32'd1);
        chk("t036_req", {31'd0, imem_req}, 32'd0);
        repeat (3) step(1'b1, 32'h200, 1'b0, 1'b1, 32'h9, "t036_abs");
        chk("t036_pc", PC, 32'h4);

        // Reset pulse while in HOLD.
        do_reset("t038_pre");
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h77, "t038_hold");
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "t038_hold2");
        do_reset("t038");

        // Randomized traffic.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset("rnd_rst");
            for (int n = 0; n < 80; n++) begin
                bit          bt, st, ak;
                logic [31:0] tg;
                ak = ($urandom_range(9) < 7);
                st = ($urandom_range(3) == 0);
                bt = ($urandom_range(11) == 0);
                tg = $urandom() & 32'hFFFF_FFFC;
                if ($urandom_range(19) == 0) tg = tg | 32'h2;
                step(bt, tg, st, ak, $urandom(), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
